// File: rtl/lpddr2_port_arbiter.sv
// lpddr2_port_arbiter
// Shares the single LPDDR2 port between the instruction-fetch requester and
// the load/store data requester. One transaction is in flight at a time:
// IDLE arbitrates (round-robin on contention), WAIT holds the registered
// command until ack or timeout, DONE pulses the granted requester's done.
// All outputs are registered; a hung memory is cut off by a WAIT-cycle
// counter that returns ERR_DATA and raises a sticky error flag.
module lpddr2_port_arbiter #(
    parameter int unsigned       ADDR_W         = 27,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_rreq,
    input  logic              d_wreq,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] lpddr2_address,
    output logic [DATA_W-1:0] lpddr2_write_data,
    input  logic [DATA_W-1:0] lpddr2_read_data,
    output logic              lpddr2_rreq,
    output logic              lpddr2_wreq,
    input  logic              lpddr2_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Registered state
    state_t              state_r;
    grant_t              last_grant_r;
    logic                op_write_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                rreq_r;
    logic                wreq_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                if_done_r;
    logic                d_done_r;
    logic                busy_r;
    logic                timeout_err_r;

    // Next-state values
    state_t              state_s;
    grant_t              last_grant_s;
    grant_t              grant_s;
    logic                op_write_s;
    logic [CNT_W-1:0]    cnt_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_s;
    logic                rreq_s;
    logic                wreq_s;
    logic [DATA_W-1:0]   if_rdata_s;
    logic [DATA_W-1:0]   d_rdata_s;
    logic                if_done_s;
    logic                d_done_s;
    logic                timeout_err_s;
    logic                busy_s;
    logic [DATA_W-1:0]   rsp_data_s;
    logic                d_active_s;

    assign d_active_s = d_rreq | d_wreq;

    // Next-state and registered-output computation for the arbiter FSM
    always_comb begin
        state_s       = state_r;
        last_grant_s  = last_grant_r;
        grant_s       = last_grant_r;
        op_write_s    = op_write_r;
        cnt_s         = cnt_r;
        addr_s        = addr_r;
        wdata_s       = wdata_r;
        rreq_s        = rreq_r;
        wreq_s        = wreq_r;
        if_rdata_s    = if_rdata_r;
        d_rdata_s     = d_rdata_r;
        if_done_s     = 1'b0;
        d_done_s      = 1'b0;
        timeout_err_s = timeout_err_r;
        rsp_data_s    = {DATA_W{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (if_req || d_active_s) begin
                    // Round-robin only matters when both are asking
                    if (if_req && d_active_s) begin
                        grant_s = (last_grant_r == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
                    end else if (d_active_s) begin
                        grant_s = GNT_DATA;
                    end else begin
                        grant_s = GNT_FETCH;
                    end
                    last_grant_s = grant_s;
                    cnt_s        = {CNT_W{1'b0}};
                    state_s      = ST_WAIT;
                    if (grant_s == GNT_DATA) begin
                        addr_s = d_addr;
                        // A write wins if the data port raises both strobes
                        if (d_wreq) begin
                            wdata_s    = d_wdata;
                            wreq_s     = 1'b1;
                            rreq_s     = 1'b0;
                            op_write_s = 1'b1;
                        end else begin
                            wreq_s     = 1'b0;
                            rreq_s     = 1'b1;
                            op_write_s = 1'b0;
                        end
                    end else begin
                        addr_s     = if_addr;
                        wreq_s     = 1'b0;
                        rreq_s     = 1'b1;
                        op_write_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WAIT: begin
                // Ack takes priority over the timeout limit in the same cycle
                if (lpddr2_ack || (cnt_r == CNT_LIMIT)) begin
                    rreq_s  = 1'b0;
                    wreq_s  = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_DONE;
                    if (lpddr2_ack) begin
                        rsp_data_s = lpddr2_read_data;
                    end else begin
                        rsp_data_s    = ERR_DATA;
                        timeout_err_s = 1'b1;
                    end
                    if (last_grant_r == GNT_DATA) begin
                        d_done_s = 1'b1;
                        if (!op_write_r) begin
                            d_rdata_s = rsp_data_s;
                        end else begin
                            d_rdata_s = d_rdata_r;
                        end
                    end else begin
                        if_done_s = 1'b1;
                        if (!op_write_r) begin
                            if_rdata_s = rsp_data_s;
                        end else begin
                            if_rdata_s = if_rdata_r;
                        end
                    end
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                rreq_s  = 1'b0;
                wreq_s  = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction without a done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GNT_DATA;
            op_write_r    <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {DATA_W{1'b0}};
            rreq_r        <= 1'b0;
            wreq_r        <= 1'b0;
            if_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r     <= {DATA_W{1'b0}};
            if_done_r     <= 1'b0;
            d_done_r      <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            last_grant_r  <= last_grant_s;
            op_write_r    <= op_write_s;
            cnt_r         <= cnt_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            rreq_r        <= rreq_s;
            wreq_r        <= wreq_s;
            if_rdata_r    <= if_rdata_s;
            d_rdata_r     <= d_rdata_s;
            if_done_r     <= if_done_s;
            d_done_r      <= d_done_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign if_rdata          = if_rdata_r;
    assign if_done           = if_done_r;
    assign d_rdata           = d_rdata_r;
    assign d_done            = d_done_r;
    assign lpddr2_address    = addr_r;
    assign lpddr2_write_data = wdata_r;
    assign lpddr2_rreq       = rreq_r;
    assign lpddr2_wreq       = wreq_r;
    assign busy              = busy_r;
    assign timeout_err       = timeout_err_r;

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Directed bench for lpddr2_port_arbiter (TIMEOUT_CYCLES=8).
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
// "cN" comments number cycles from the cycle in which a request is first seen in IDLE.
module tb_lpddr2_port_arbiter;

    localparam int          ADDR_W = 27;
    localparam int          DATA_W = 32;
    localparam logic [31:0] ERR    = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              d_rreq;
    logic              d_wreq;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic [ADDR_W-1:0] lpddr2_address;
    logic [DATA_W-1:0] lpddr2_write_data;
    logic [DATA_W-1:0] lpddr2_read_data;
    logic              lpddr2_rreq;
    logic              lpddr2_wreq;
    logic              lpddr2_ack;
    logic              busy;
    logic              timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    lpddr2_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_rreq(d_rreq), .d_wreq(d_wreq), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
        .lpddr2_read_data(lpddr2_read_data), .lpddr2_rreq(lpddr2_rreq),
        .lpddr2_wreq(lpddr2_wreq), .lpddr2_ack(lpddr2_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b0;
        if_req = 1'b0; d_rreq = 1'b0; d_wreq = 1'b0; lpddr2_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        sample();
        tests_run++; if ({if_done, d_done, lpddr2_rreq, lpddr2_wreq, busy, timeout_err} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 000000", {if_done, d_done, lpddr2_rreq, lpddr2_wreq, busy, timeout_err}); end
        tests_run++; if ({if_rdata, d_rdata, lpddr2_write_data} !== 96'h0) begin
            tests_failed++; $display("FAIL reset_data: got %h expected 0", {if_rdata, d_rdata, lpddr2_write_data}); end
        tests_run++; if (lpddr2_address !== 27'h0) begin
            tests_failed++; $display("FAIL reset_addr: got %h expected 0", lpddr2_address); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        step(); if_req = 1'b1; if_addr = 27'h10;                 // c0
        step(); sample();                                        // c1
        tests_run++; if (lpddr2_rreq !== 1'b1 || lpddr2_wreq !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_rreq_c1: got rreq=%b wreq=%b expected 1 0", lpddr2_rreq, lpddr2_wreq); end
        tests_run++; if (lpddr2_address !== 27'h10) begin
            tests_failed++; $display("FAIL fetch_addr: got %h expected 10", lpddr2_address); end
        tests_run++; if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL fetch_busy: got %b expected 1", busy); end
        step(); sample();                                        // c2
        tests_run++; if (lpddr2_rreq !== 1'b1 || if_done !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_hold_c2: got rreq=%b done=%b expected 1 0", lpddr2_rreq, if_done); end
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h12345678; // c3
        sample();
        tests_run++; if (if_done !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_early_done: got %b expected 0", if_done); end
        step(); lpddr2_ack = 1'b0; lpddr2_read_data = 32'h0;     // c4
        sample();
        tests_run++; if (if_done !== 1'b1 || d_done !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_done: got if_done=%b d_done=%b expected 1 0", if_done, d_done); end
        tests_run++; if (if_rdata !== 32'h12345678) begin
            tests_failed++; $display("FAIL fetch_rdata: got %h expected 12345678", if_rdata); end
        tests_run++; if (lpddr2_rreq !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_rreq_drop: got %b expected 0", lpddr2_rreq); end
        step(); if_req = 1'b0;                                   // c5
        sample();
        tests_run++; if (if_done !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h12345678) begin
            tests_failed++; $display("FAIL fetch_after: got done=%b busy=%b rdata=%h expected 0 0 12345678", if_done, busy, if_rdata); end
    endtask

    task automatic test_data_write();
        step(); d_wreq = 1'b1; d_addr = 27'h20; d_wdata = 32'hCAFEF00D; // c0
        step(); sample();                                        // c1
        tests_run++; if (lpddr2_wreq !== 1'b1 || lpddr2_rreq !== 1'b0) begin
            tests_failed++; $display("FAIL wr_strobes: got wreq=%b rreq=%b expected 1 0", lpddr2_wreq, lpddr2_rreq); end
        tests_run++; if (lpddr2_write_data !== 32'hCAFEF00D || lpddr2_address !== 27'h20) begin
            tests_failed++; $display("FAIL wr_cmd: got data=%h addr=%h expected cafef00d 20", lpddr2_write_data, lpddr2_address); end
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h55555555; // c2
        sample();
        tests_run++; if (lpddr2_rreq !== 1'b0 || lpddr2_wreq !== 1'b1) begin
            tests_failed++; $display("FAIL wr_hold: got rreq=%b wreq=%b expected 0 1", lpddr2_rreq, lpddr2_wreq); end
        step(); lpddr2_ack = 1'b0;                               // c3
        sample();
        tests_run++; if (d_done !== 1'b1 || if_done !== 1'b0) begin
            tests_failed++; $display("FAIL wr_done: got d_done=%b if_done=%b expected 1 0", d_done, if_done); end
        tests_run++; if (d_rdata !== 32'h0 || if_rdata !== 32'h12345678) begin
            tests_failed++; $display("FAIL wr_rdata: got d=%h if=%h expected 0 12345678", d_rdata, if_rdata); end
        tests_run++; if (lpddr2_wreq !== 1'b0 || lpddr2_rreq !== 1'b0) begin
            tests_failed++; $display("FAIL wr_drop: got wreq=%b rreq=%b expected 0 0", lpddr2_wreq, lpddr2_rreq); end
        step(); d_wreq = 1'b0;                                   // c4
        sample();
        tests_run++; if (d_done !== 1'b0) begin
            tests_failed++; $display("FAIL wr_done_once: got %b expected 0", d_done); end
    endtask

    task automatic test_ack_idle();
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h99999999;
        sample();
        tests_run++; if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL idle_ack_busy: got %b expected 0", busy); end
        step(); lpddr2_ack = 1'b0;
        sample();
        tests_run++; if (if_done !== 1'b0 || d_done !== 1'b0 || if_rdata !== 32'h12345678 || d_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL idle_ack_ignored: got %b %b %h %h expected 0 0 12345678 0", if_done, d_done, if_rdata, d_rdata); end
    endtask

    task automatic test_both_dreq();
        step(); d_rreq = 1'b1; d_wreq = 1'b1; d_addr = 27'h25; d_wdata = 32'h0BADF00D; // c0
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h77777777; // c1
        sample();
        tests_run++; if (lpddr2_wreq !== 1'b1 || lpddr2_rreq !== 1'b0 || lpddr2_write_data !== 32'h0BADF00D) begin
            tests_failed++; $display("FAIL both_is_write: got wreq=%b rreq=%b wd=%h expected 1 0 0badf00d", lpddr2_wreq, lpddr2_rreq, lpddr2_write_data); end
        step(); lpddr2_ack = 1'b0;                               // c2
        sample();
        tests_run++; if (d_done !== 1'b1 || d_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL both_done: got done=%b rdata=%h expected 1 0", d_done, d_rdata); end
        step(); d_rreq = 1'b0; d_wreq = 1'b0;
    endtask

    task automatic test_contention();
        apply_reset();
        step(); if_req = 1'b1; if_addr = 27'h30; d_rreq = 1'b1; d_addr = 27'h40; // c0
        step(); sample();                                        // c1
        tests_run++; if (lpddr2_address !== 27'h30 || lpddr2_rreq !== 1'b1) begin
            tests_failed++; $display("FAIL cont_first_fetch: got addr=%h rreq=%b expected 30 1", lpddr2_address, lpddr2_rreq); end
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'hA1A1A1A1; // c2
        step(); lpddr2_ack = 1'b0;                               // c3
        sample();
        tests_run++; if (if_done !== 1'b1 || d_done !== 1'b0 || if_rdata !== 32'hA1A1A1A1) begin
            tests_failed++; $display("FAIL cont_fetch_done: got %b %b %h expected 1 0 a1a1a1a1", if_done, d_done, if_rdata); end
        step(); if_req = 1'b0;                                   // c4 idle gap
        sample();
        tests_run++; if (busy !== 1'b0 || lpddr2_rreq !== 1'b0) begin
            tests_failed++; $display("FAIL cont_gap: got busy=%b rreq=%b expected 0 0", busy, lpddr2_rreq); end
        step(); sample();                                        // c5
        tests_run++; if (lpddr2_address !== 27'h40 || lpddr2_rreq !== 1'b1) begin
            tests_failed++; $display("FAIL cont_data_second: got addr=%h rreq=%b expected 40 1", lpddr2_address, lpddr2_rreq); end
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'hB2B2B2B2; // c6
        step(); lpddr2_ack = 1'b0;                               // c7
        sample();
        tests_run++; if (d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== 32'hB2B2B2B2) begin
            tests_failed++; $display("FAIL cont_data_done: got %b %b %h expected 1 0 b2b2b2b2", d_done, if_done, d_rdata); end
        // Third pair: data was last, so fetch wins again; ack on first WAIT cycle
        step(); if_req = 1'b1; if_addr = 27'h50; d_rreq = 1'b1; d_addr = 27'h60; // c8
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'hC3C3C3C3; // c9
        sample();
        tests_run++; if (lpddr2_address !== 27'h50) begin
            tests_failed++; $display("FAIL cont_third_fetch: got %h expected 50", lpddr2_address); end
        step(); lpddr2_ack = 1'b0;                               // c10
        sample();
        tests_run++; if (if_done !== 1'b1 || if_rdata !== 32'hC3C3C3C3) begin
            tests_failed++; $display("FAIL cont_min_latency: got done=%b rdata=%h expected 1 c3c3c3c3", if_done, if_rdata); end
        step(); if_req = 1'b0;                                   // c11
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'hD4D4D4D4; // c12
        sample();
        tests_run++; if (lpddr2_address !== 27'h60 || lpddr2_rreq !== 1'b1) begin
            tests_failed++; $display("FAIL cont_third_data: got addr=%h rreq=%b expected 60 1", lpddr2_address, lpddr2_rreq); end
        step(); lpddr2_ack = 1'b0;                               // c13
        sample();
        tests_run++; if (d_done !== 1'b1 || d_rdata !== 32'hD4D4D4D4) begin
            tests_failed++; $display("FAIL cont_third_data_done: got %b %h expected 1 d4d4d4d4", d_done, d_rdata); end
        step(); d_rreq = 1'b0;
    endtask

    task automatic test_timeout();
        step(); d_rreq = 1'b1; d_addr = 27'h70;                  // c0
        for (int c = 1; c <= 8; c++) begin
            step(); sample();
            tests_run++; if (lpddr2_rreq !== 1'b1 || d_done !== 1'b0) begin
                tests_failed++; $display("FAIL to_wait_c%0d: got rreq=%b done=%b expected 1 0", c, lpddr2_rreq, d_done); end
        end
        step(); sample();                                        // c9
        tests_run++; if (lpddr2_rreq !== 1'b0 || d_done !== 1'b1) begin
            tests_failed++; $display("FAIL to_abort: got rreq=%b done=%b expected 0 1", lpddr2_rreq, d_done); end
        tests_run++; if (d_rdata !== ERR || timeout_err !== 1'b1) begin
            tests_failed++; $display("FAIL to_err: got rdata=%h err=%b expected deadbeef 1", d_rdata, timeout_err); end
        step(); d_rreq = 1'b0;                                   // c10
        sample();
        tests_run++; if (d_done !== 1'b0) begin
            tests_failed++; $display("FAIL to_done_once: got %b expected 0", d_done); end
        step(); if_req = 1'b1; if_addr = 27'h71;
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h13579BDF;
        step(); lpddr2_ack = 1'b0;
        sample();
        tests_run++; if (if_done !== 1'b1 || if_rdata !== 32'h13579BDF || timeout_err !== 1'b1) begin
            tests_failed++; $display("FAIL to_sticky: got done=%b rdata=%h err=%b expected 1 13579bdf 1", if_done, if_rdata, timeout_err); end
        step(); if_req = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        step(); if_req = 1'b1; if_addr = 27'h90;                 // c0
        step(); sample();                                        // c1
        tests_run++; if (lpddr2_rreq !== 1'b1) begin
            tests_failed++; $display("FAIL rmw_rreq: got %b expected 1", lpddr2_rreq); end
        step(); rst = 1'b0; if_req = 1'b0;                       // c2, asynchronous
        #1;
        tests_run++; if ({lpddr2_rreq, lpddr2_wreq, busy, timeout_err, if_done, d_done} !== 6'b0) begin
            tests_failed++; $display("FAIL rmw_flags: got %b expected 000000", {lpddr2_rreq, lpddr2_wreq, busy, timeout_err, if_done, d_done}); end
        tests_run++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || lpddr2_address !== 27'h0) begin
            tests_failed++; $display("FAIL rmw_data: got %h %h %h expected 0 0 0", if_rdata, d_rdata, lpddr2_address); end
        for (int c = 0; c < 3; c++) begin
            step(); sample();
            tests_run++; if (if_done !== 1'b0 || d_done !== 1'b0) begin
                tests_failed++; $display("FAIL rmw_no_done_%0d: got %b %b expected 0 0", c, if_done, d_done); end
        end
        step(); rst = 1'b1;
        step(); if_req = 1'b1; if_addr = 27'hA0;                 // c0
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h11223344; // c1
        sample();
        tests_run++; if (lpddr2_rreq !== 1'b1 || lpddr2_address !== 27'hA0) begin
            tests_failed++; $display("FAIL rmw_resume: got rreq=%b addr=%h expected 1 a0", lpddr2_rreq, lpddr2_address); end
        step(); lpddr2_ack = 1'b0;                               // c2
        sample();
        tests_run++; if (if_done !== 1'b1 || if_rdata !== 32'h11223344) begin
            tests_failed++; $display("FAIL rmw_resume_done: got %b %h expected 1 11223344", if_done, if_rdata); end
        step(); if_req = 1'b0;
    endtask

    task automatic test_ack_on_limit();
        step(); d_rreq = 1'b1; d_addr = 27'h80;                  // c0
        for (int c = 1; c <= 7; c++) begin
            step(); sample();
            tests_run++; if (lpddr2_rreq !== 1'b1 || d_done !== 1'b0) begin
                tests_failed++; $display("FAIL lim_wait_c%0d: got rreq=%b done=%b expected 1 0", c, lpddr2_rreq, d_done); end
        end
        step(); lpddr2_ack = 1'b1; lpddr2_read_data = 32'h0A0B0C0D; // c8, counter at limit
        sample();
        tests_run++; if (lpddr2_rreq !== 1'b1) begin
            tests_failed++; $display("FAIL lim_rreq_c8: got %b expected 1", lpddr2_rreq); end
        step(); lpddr2_ack = 1'b0;                               // c9
        sample();
        tests_run++; if (d_done !== 1'b1 || d_rdata !== 32'h0A0B0C0D || timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL lim_ack_wins: got done=%b rdata=%h err=%b expected 1 0a0b0c0d 0", d_done, d_rdata, timeout_err); end
        step(); d_rreq = 1'b0;                                   // c10
        sample();
        tests_run++; if (d_done !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            tests_failed++; $display("FAIL lim_after: got %b %b %b expected 0 0 0", d_done, busy, timeout_err); end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = 27'h0;
        d_rreq = 1'b0; d_wreq = 1'b0; d_addr = 27'h0; d_wdata = 32'h0;
        lpddr2_read_data = 32'h0; lpddr2_ack = 1'b0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_ack_idle();
        test_both_dreq();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        test_ack_on_limit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
